// File: rtl/video_timing_gen_il.sv
// Raster timing generator with progressive or interlaced output (per-field vertical
// timing, offset vsync on field 1) and selectable RGB565/RGB888 test patterns.
module video_timing_gen_il #(
    parameter int          DATA_W      = 16,
    parameter bit          INTERLACED  = 1'b1,
    parameter int          H_ACTIVE    = 768,
    parameter int          H_TOTAL     = 944,
    parameter int          H_FP        = 12,
    parameter int          H_SYNC      = 100,
    parameter int          V_ACTIVE_0  = 288,
    parameter int          V_TOTAL_0   = 312,
    parameter int          V_FP_0      = 6,
    parameter int          V_SYNC_0    = 5,
    parameter int          V_ACTIVE_1  = 288,
    parameter int          V_TOTAL_1   = 313,
    parameter int          V_FP_1      = 6,
    parameter int          V_SYNC_1    = 5,
    parameter int          HV_OFFSET_0 = 0,
    parameter int          HV_OFFSET_1 = 472,
    parameter bit          SYNC_POL    = 1'b1,
    parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic [1:0]        pattern_sel_i,
    output logic              de_o,
    output logic              hs_o,
    output logic              vs_o,
    output logic              field_o,
    output logic [DATA_W-1:0] data_o,
    output logic [11:0]       h_cnt_o,
    output logic [11:0]       v_cnt_o,
    output logic [11:0]       x_cnt_o,
    output logic [11:0]       y_cnt_o,
    output logic              sof_o,
    output logic              eol_o
);

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] BW_LAST  = 12'(H_ACTIVE / 8 - 1);
    localparam logic [11:0] V_LAST_0 = 12'(V_TOTAL_0 - 1);
    localparam logic [11:0] V_LAST_1 = 12'(V_TOTAL_1 - 1);
    localparam logic [11:0] VA_0     = 12'(V_ACTIVE_0);
    localparam logic [11:0] VA_1     = 12'(V_ACTIVE_1);
    localparam logic [11:0] VS_BEG_0 = 12'(V_ACTIVE_0 + V_FP_0);
    localparam logic [11:0] VS_BEG_1 = 12'(V_ACTIVE_1 + V_FP_1);
    localparam logic [11:0] VS_END_0 = 12'(V_ACTIVE_0 + V_FP_0 + V_SYNC_0);
    localparam logic [11:0] VS_END_1 = 12'(V_ACTIVE_1 + V_FP_1 + V_SYNC_1);
    localparam logic [11:0] OFF_0    = 12'(HV_OFFSET_0);
    localparam logic [11:0] OFF_1    = 12'(HV_OFFSET_1);

    if (!(DATA_W == 16 || DATA_W == 24)) begin : g_bad_data_w
        $error("DATA_W must be 16 or 24");
    end
    if (H_ACTIVE < 8 || H_ACTIVE + H_FP + H_SYNC >= H_TOTAL || H_TOTAL > 4096) begin : g_bad_h
        $error("inconsistent horizontal timing");
    end
    if (V_ACTIVE_0 + V_FP_0 + V_SYNC_0 >= V_TOTAL_0 ||
        V_ACTIVE_1 + V_FP_1 + V_SYNC_1 >= V_TOTAL_1) begin : g_bad_v
        $error("inconsistent vertical timing");
    end
    if (HV_OFFSET_0 >= H_TOTAL || HV_OFFSET_1 >= H_TOTAL) begin : g_bad_off
        $error("vsync offset outside line");
    end

    function automatic logic [DATA_W-1:0] pack(input logic [7:0] r, input logic [7:0] g,
                                               input logic [7:0] b);
        return (DATA_W == 24) ? DATA_W'({r, g, b}) : DATA_W'({r[7:3], g[7:2], b[7:3]});
    endfunction

    logic [11:0]       h_q, h_d, v_q, v_d, bar_cnt_q, bar_cnt_d;
    logic [2:0]        bar_idx_q, bar_idx_d;
    logic              field_q, field_d;
    logic [1:0]        pat_q, pat_cur;
    logic              frame_start, h_wrap, h_act, v_act, de_d, hs_on, vs_on, eol_d;
    logic [11:0]       v_last, vs_beg, vs_end, hv_off, x_d, y_d;
    logic [DATA_W-1:0] data_d;
    logic              bar_r, bar_g, bar_b;
    logic [7:0]        grey;

    always_comb begin
        frame_start = (h_q == '0) && (v_q == '0) && !field_q;
        h_wrap      = (h_q == H_LAST);
        v_last      = field_q ? V_LAST_1 : V_LAST_0;

        h_d     = h_wrap ? '0 : h_q + 12'd1;
        v_d     = v_q;
        field_d = field_q;
        if (h_wrap) begin
            if (v_q == v_last) begin
                v_d     = '0;
                field_d = INTERLACED ? ~field_q : 1'b0;
            end else begin
                v_d = v_q + 12'd1;
            end
        end

        // Bar index advances every BW pixels and sticks at 7 to absorb the remainder.
        if (h_wrap) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_cnt_q == BW_LAST && bar_idx_q != 3'd7) begin
            bar_cnt_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end else begin
            bar_cnt_d = bar_cnt_q + 12'd1;
            bar_idx_d = bar_idx_q;
        end

        pat_cur = frame_start ? pattern_sel_i : pat_q;

        h_act = (h_q < H_ACT);
        v_act = (v_q < (field_q ? VA_1 : VA_0));
        de_d  = h_act && v_act;
        eol_d = (h_q == H_ACT - 12'd1) && v_act;
        hs_on = (h_q >= HS_BEG) && (h_q < HS_END);

        vs_beg = field_q ? VS_BEG_1 : VS_BEG_0;
        vs_end = field_q ? VS_END_1 : VS_END_0;
        hv_off = field_q ? OFF_1 : OFF_0;
        vs_on  = ((v_q > vs_beg) || ((v_q == vs_beg) && (h_q >= hv_off))) &&
                 ((v_q < vs_end) || ((v_q == vs_end) && (h_q < hv_off)));

        x_d = de_d ? h_q : '0;
        y_d = INTERLACED ? {v_q[10:0], field_q} : v_q;

        bar_g = ~bar_idx_q[2];
        bar_r = ~bar_idx_q[1];
        bar_b = ~bar_idx_q[0];
        grey  = x_d[7:0];

        data_d = '0;
        if (de_d) begin
            case (pat_cur)
                2'd0: data_d = pack({8{bar_r}}, {8{bar_g}}, {8{bar_b}});
                2'd1: data_d = pack(grey, grey, grey);
                2'd2: data_d = DATA_W'(SOLID_COLOR);
                default: data_d = (x_d[5] ^ y_d[5]) ? pack(8'hFF, 8'hFF, 8'hFF) : '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || !enable_i) begin
            h_q       <= '0;
            v_q       <= '0;
            field_q   <= 1'b0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            pat_q     <= '0;
            de_o      <= 1'b0;
            hs_o      <= ~SYNC_POL;
            vs_o      <= ~SYNC_POL;
            field_o   <= 1'b0;
            data_o    <= '0;
            h_cnt_o   <= '0;
            v_cnt_o   <= '0;
            x_cnt_o   <= '0;
            y_cnt_o   <= '0;
            sof_o     <= 1'b0;
            eol_o     <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            field_q   <= field_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_cur;
            de_o      <= de_d;
            hs_o      <= SYNC_POL ? hs_on : ~hs_on;
            vs_o      <= SYNC_POL ? vs_on : ~vs_on;
            field_o   <= field_q;
            data_o    <= data_d;
            h_cnt_o   <= h_q;
            v_cnt_o   <= v_q;
            x_cnt_o   <= x_d;
            y_cnt_o   <= y_d;
            sof_o     <= frame_start;
            eol_o     <= eol_d;
        end
    end

endmodule

// File: tb/tb_video_timing_gen_il.sv
// Directed-vector bench: interlaced RGB565 instance (A) and progressive RGB888
// active-low-sync instance (B), both with default horizontals and short fields.
module tb_video_timing_gen_il;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable;
    logic [1:0]  pat_a, pat_b;
    logic        de_a, hs_a, vs_a, fld_a, sof_a, eol_a;
    logic [15:0] data_a;
    logic [11:0] h_a, v_a, x_a, y_a;
    logic        de_b, hs_b, vs_b, fld_b, sof_b, eol_b;
    logic [23:0] data_b;
    logic [11:0] h_b, v_b, x_b, y_b;

    video_timing_gen_il #(
        .DATA_W(16), .INTERLACED(1'b1),
        .V_ACTIVE_0(4), .V_TOTAL_0(10), .V_FP_0(1), .V_SYNC_0(2),
        .V_ACTIVE_1(4), .V_TOTAL_1(11), .V_FP_1(1), .V_SYNC_1(2),
        .HV_OFFSET_0(0), .HV_OFFSET_1(472), .SYNC_POL(1'b1)
    ) dut_a (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .pattern_sel_i(pat_a),
        .de_o(de_a), .hs_o(hs_a), .vs_o(vs_a), .field_o(fld_a), .data_o(data_a),
        .h_cnt_o(h_a), .v_cnt_o(v_a), .x_cnt_o(x_a), .y_cnt_o(y_a),
        .sof_o(sof_a), .eol_o(eol_a)
    );

    video_timing_gen_il #(
        .DATA_W(24), .INTERLACED(1'b0),
        .V_ACTIVE_0(4), .V_TOTAL_0(6), .V_FP_0(0), .V_SYNC_0(1),
        .SYNC_POL(1'b0)
    ) dut_b (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .pattern_sel_i(pat_b),
        .de_o(de_b), .hs_o(hs_b), .vs_o(vs_b), .field_o(fld_b), .data_o(data_b),
        .h_cnt_o(h_b), .v_cnt_o(v_b), .x_cnt_o(x_b), .y_cnt_o(y_b),
        .sof_o(sof_b), .eol_o(eol_b)
    );

    typedef struct {
        bit          b;
        int          t;
        logic        de, hs, vs, fld, sof, eol;
        logic [11:0] h, v, x, y;
        logic [23:0] data;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   table_phase = 1'b0;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input bit b, input int t, input logic de, input logic hs, input logic vs,
                       input logic fld, input logic sof, input logic eol, input int h,
                       input int v, input int x, input int y, input logic [23:0] data);
        vec_t e;
        e.b = b; e.t = t; e.de = de; e.hs = hs; e.vs = vs; e.fld = fld;
        e.sof = sof; e.eol = eol; e.h = 12'(h); e.v = 12'(v); e.x = 12'(x); e.y = 12'(y);
        e.data = data;
        vecs.push_back(e);
    endtask

    // Counter state t is reflected on the outputs after edge t+1 of the run.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (table_phase) begin
            if (cyc == 3000)  pat_b = 2'd1;
            if (cyc == 9500)  pat_a = 2'd2;
            if (cyc == 20000) pat_a = 2'd3;
        end
    endtask

    task automatic check_vec(input vec_t e, input int k);
        string n;
        n = $sformatf("%s%0d_t%0d", e.b ? "B" : "A", k, e.t);
        chk({n, ".de"},    24'(e.b ? de_b  : de_a),  24'(e.de));
        chk({n, ".hs"},    24'(e.b ? hs_b  : hs_a),  24'(e.hs));
        chk({n, ".vs"},    24'(e.b ? vs_b  : vs_a),  24'(e.vs));
        chk({n, ".field"}, 24'(e.b ? fld_b : fld_a), 24'(e.fld));
        chk({n, ".sof"},   24'(e.b ? sof_b : sof_a), 24'(e.sof));
        chk({n, ".eol"},   24'(e.b ? eol_b : eol_a), 24'(e.eol));
        chk({n, ".h"},     24'(e.b ? h_b   : h_a),   24'(e.h));
        chk({n, ".v"},     24'(e.b ? v_b   : v_a),   24'(e.v));
        chk({n, ".x"},     24'(e.b ? x_b   : x_a),   24'(e.x));
        chk({n, ".y"},     24'(e.b ? y_b   : y_a),   24'(e.y));
        chk({n, ".data"},  e.b ? data_b : {8'h00, data_a}, e.data);
    endtask

    task automatic chk_idle(input string n);
        chk({n, ".de"},    24'(de_a),   24'(0));
        chk({n, ".hs"},    24'(hs_a),   24'(0));
        chk({n, ".vs"},    24'(vs_a),   24'(0));
        chk({n, ".field"}, 24'(fld_a),  24'(0));
        chk({n, ".sof"},   24'(sof_a),  24'(0));
        chk({n, ".eol"},   24'(eol_a),  24'(0));
        chk({n, ".data"},  24'(data_a), 24'(0));
        chk({n, ".h"},     24'(h_a),    24'(0));
        chk({n, ".v"},     24'(v_a),    24'(0));
        chk({n, ".x"},     24'(x_a),    24'(0));
        chk({n, ".y"},     24'(y_a),    24'(0));
        chk({n, ".b_hs"},  24'(hs_b),   24'(1));
        chk({n, ".b_vs"},  24'(vs_b),   24'(1));
        chk({n, ".b_de"},  24'(de_b),   24'(0));
        chk({n, ".b_data"}, data_b,     24'(0));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; pat_a = 2'd0; pat_b = 2'd0;

        //   b  t      de hs vs f sof eol  h    v   x    y   data
        add(0, 0,     1, 0, 0, 0, 1, 0,   0,   0,  0,   0,  24'hFFFF);
        add(1, 0,     1, 1, 1, 0, 1, 0,   0,   0,  0,   0,  24'hFFFFFF);
        add(0, 1,     1, 0, 0, 0, 0, 0,   1,   0,  1,   0,  24'hFFFF);
        add(0, 95,    1, 0, 0, 0, 0, 0,   95,  0,  95,  0,  24'hFFFF);
        add(0, 96,    1, 0, 0, 0, 0, 0,   96,  0,  96,  0,  24'hFFE0);
        add(1, 96,    1, 1, 1, 0, 0, 0,   96,  0,  96,  0,  24'hFFFF00);
        add(0, 191,   1, 0, 0, 0, 0, 0,   191, 0,  191, 0,  24'hFFE0);
        add(0, 192,   1, 0, 0, 0, 0, 0,   192, 0,  192, 0,  24'h07FF);
        add(1, 200,   1, 1, 1, 0, 0, 0,   200, 0,  200, 0,  24'h00FFFF);
        add(0, 671,   1, 0, 0, 0, 0, 0,   671, 0,  671, 0,  24'h001F);
        add(0, 672,   1, 0, 0, 0, 0, 0,   672, 0,  672, 0,  24'h0000);
        add(0, 767,   1, 0, 0, 0, 0, 1,   767, 0,  767, 0,  24'h0000);
        add(0, 768,   0, 0, 0, 0, 0, 0,   768, 0,  0,   0,  24'h0);
        add(0, 779,   0, 0, 0, 0, 0, 0,   779, 0,  0,   0,  24'h0);
        add(0, 780,   0, 1, 0, 0, 0, 0,   780, 0,  0,   0,  24'h0);
        add(1, 780,   0, 0, 1, 0, 0, 0,   780, 0,  0,   0,  24'h0);
        add(0, 879,   0, 1, 0, 0, 0, 0,   879, 0,  0,   0,  24'h0);
        add(0, 880,   0, 0, 0, 0, 0, 0,   880, 0,  0,   0,  24'h0);
        add(0, 944,   1, 0, 0, 0, 0, 0,   0,   1,  0,   2,  24'hFFFF);
        add(1, 944,   1, 1, 1, 0, 0, 0,   0,   1,  0,   1,  24'hFFFFFF);
        add(0, 3776,  0, 0, 0, 0, 0, 0,   0,   4,  0,   8,  24'h0);
        add(1, 3776,  0, 1, 0, 0, 0, 0,   0,   4,  0,   4,  24'h0);
        add(0, 4719,  0, 0, 0, 0, 0, 0,   943, 4,  0,   8,  24'h0);
        add(0, 4720,  0, 0, 1, 0, 0, 0,   0,   5,  0,   10, 24'h0);
        add(1, 4720,  0, 1, 1, 0, 0, 0,   0,   5,  0,   5,  24'h0);
        add(1, 5664,  1, 1, 1, 0, 1, 0,   0,   0,  0,   0,  24'h000000);
        add(1, 5864,  1, 1, 1, 0, 0, 0,   200, 0,  200, 0,  24'hC8C8C8);
        add(1, 5964,  1, 1, 1, 0, 0, 0,   300, 0,  300, 0,  24'h2C2C2C);
        add(0, 6607,  0, 0, 1, 0, 0, 0,   943, 6,  0,   12, 24'h0);
        add(0, 6608,  0, 0, 0, 0, 0, 0,   0,   7,  0,   14, 24'h0);
        add(0, 9439,  0, 0, 0, 0, 0, 0,   943, 9,  0,   18, 24'h0);
        add(0, 9440,  1, 0, 0, 1, 0, 0,   0,   0,  0,   1,  24'hFFFF);
        add(0, 11428, 1, 0, 0, 1, 0, 0,   100, 2,  100, 5,  24'hFFE0);
        add(0, 13039, 1, 0, 0, 1, 0, 1,   767, 3,  767, 7,  24'h0);
        add(0, 14631, 0, 0, 0, 1, 0, 0,   471, 5,  0,   11, 24'h0);
        add(0, 14632, 0, 0, 1, 1, 0, 0,   472, 5,  0,   11, 24'h0);
        add(0, 16519, 0, 0, 1, 1, 0, 0,   471, 7,  0,   15, 24'h0);
        add(0, 16520, 0, 0, 0, 1, 0, 0,   472, 7,  0,   15, 24'h0);
        add(0, 18880, 0, 0, 0, 1, 0, 0,   0,   10, 0,   21, 24'h0);
        add(0, 19823, 0, 0, 0, 1, 0, 0,   943, 10, 0,   21, 24'h0);
        add(0, 19824, 1, 0, 0, 0, 1, 0,   0,   0,  0,   0,  24'hF800);
        add(0, 19920, 1, 0, 0, 0, 0, 0,   96,  0,  96,  0,  24'hF800);
        add(0, 21568, 0, 1, 0, 0, 0, 0,   800, 1,  0,   2,  24'h0);
        add(0, 39648, 1, 0, 0, 0, 1, 0,   0,   0,  0,   0,  24'h0);
        add(0, 39679, 1, 0, 0, 0, 0, 0,   31,  0,  31,  0,  24'h0);
        add(0, 39680, 1, 0, 0, 0, 0, 0,   32,  0,  32,  0,  24'hFFFF);
        add(0, 39712, 1, 0, 0, 0, 0, 0,   64,  0,  64,  0,  24'h0);

        repeat (3) tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();
        chk_idle("disabled");

        enable = 1'b1;
        cyc = 0;
        table_phase = 1'b1;
        foreach (vecs[k]) begin
            while (cyc < vecs[k].t + 1) tick();
            check_vec(vecs[k], k);
        end
        table_phase = 1'b0;

        // Reset in the middle of an active line of field 0.
        while (cyc < 40693) tick();
        chk("midrst.pre_de", 24'(de_a), 24'(1));
        reset = 1'b1;
        tick();
        chk_idle("midrst");
        reset = 1'b0;
        tick();
        cyc = 1;
        chk("rst_restart.de",  24'(de_a),  24'(1));
        chk("rst_restart.sof", 24'(sof_a), 24'(1));
        chk("rst_restart.h",   24'(h_a),   24'(0));
        chk("rst_restart.v",   24'(v_a),   24'(0));

        // Drop enable while in field 1.
        while (cyc < 9941) tick();
        chk("dis.pre_field", 24'(fld_a), 24'(1));
        enable = 1'b0;
        tick();
        chk_idle("dis1");
        repeat (2) tick();
        chk_idle("dis3");
        enable = 1'b1;
        tick();
        chk("en_restart.de",    24'(de_a),  24'(1));
        chk("en_restart.sof",   24'(sof_a), 24'(1));
        chk("en_restart.h",     24'(h_a),   24'(0));
        chk("en_restart.v",     24'(v_a),   24'(0));
        chk("en_restart.field", 24'(fld_a), 24'(0));
        chk("en_restart.b_sof", 24'(sof_b), 24'(1));
        tick();
        chk("en_next.h",   24'(h_a),   24'(1));
        chk("en_next.x",   24'(x_a),   24'(1));
        chk("en_next.sof", 24'(sof_a), 24'(0));
        chk("en_next.de",  24'(de_a),  24'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_timing_gen_il.md
Name: video_timing_gen_il

Overview:
- Parametrised successor to the fixed-mode colour-bar generator plus interlacer pair.
- One block produces complete raster timing in either progressive or interlaced mode. In interlaced mode it uses independent per-field vertical timing and a half-line vsync offset on field 1.
- Pixel data comes from a runtime-selectable test pattern at 16-bit (RGB565) or 24-bit (RGB888) width.
- Sits between the system clock and the HDMI transmitter pins in the top level.

Parameters:
- DATA_W, 16, pixel width; legal values are 16 (RGB565) or 24 (RGB888).
- INTERLACED, 1, 0 = progressive (field 0 timing only), 1 = alternate field 0 and field 1.
- H_ACTIVE, 768, active pixels per line.
- H_TOTAL, 944, clocks per line.
- H_FP, 12, horizontal front porch.
- H_SYNC, 100, hsync width.
- V_ACTIVE_0, 288, active lines in field 0.
- V_TOTAL_0, 312, total lines in field 0.
- V_FP_0, 6, field 0 vertical front porch.
- V_SYNC_0, 5, field 0 vsync width in lines.
- V_ACTIVE_1, 288, active lines in field 1.
- V_TOTAL_1, 313, total lines in field 1.
- V_FP_1, 6, field 1 vertical front porch.
- V_SYNC_1, 5, field 1 vsync width in lines.
- HV_OFFSET_0, 0, h_cnt value at which field 0 vsync changes.
- HV_OFFSET_1, 472, h_cnt value at which field 1 vsync changes.
- SYNC_POL, 1, 1 = hs/vs active high, 0 = active low.
- SOLID_COLOR, 16'hF800, pixel value for the solid pattern; zero-extended to DATA_W.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous reset, active high.
- enable  in  1  run when high; when low, counters are held at the origin.
- pattern_sel  in  2  0 = colour bars, 1 = ramp, 2 = solid, 3 = checkerboard.
- de  out  1  data enable.
- hs  out  1  hsync.
- vs  out  1  vsync.
- field  out  1  current field (0 or 1).
- data  out  DATA_W  pixel data.
- h_cnt  out  12  horizontal counter, 0..H_TOTAL-1.
- v_cnt  out  12  line within field, 0..V_TOTAL_f-1.
- x_cnt  out  12  active pixel index, 0 outside active region.
- y_cnt  out  12  frame line index: 2*v_cnt+field when interlaced, v_cnt when progressive.
- sof  out  1  one-cycle pulse, first active pixel of a frame (field 0).
- eol  out  1  one-cycle pulse, last active pixel of each active line.

Behaviour:
- Reset and disabled state:
  - All counters, field, de, sof, eol and data are 0.
  - hs and vs are driven inactive (= ~SYNC_POL).
  - enable low gives the same state as reset.
  - On the first enable-high cycle, counting starts at h=0, v=0, field 0.
- Counters:
  - h_cnt increments every enabled cycle and wraps at H_TOTAL-1.
  - v_cnt increments on the h_cnt wrap and wraps at V_TOTAL_f-1, where f is the current field.
  - On the v wrap, field toggles if INTERLACED=1 and stays 0 otherwise.
- Horizontal timing:
  - Active region: h_cnt < H_ACTIVE.
  - hs asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - Back porch is the remainder of the line.
- Vertical timing:
  - Active region: v_cnt < V_ACTIVE_f.
  - vs asserts at (v_cnt = V_ACTIVE_f+V_FP_f, h_cnt = HV_OFFSET_f).
  - vs deasserts at (v_cnt = V_ACTIVE_f+V_FP_f+V_SYNC_f, h_cnt = HV_OFFSET_f).
  - This gives the field 1 half-line offset.
- Latency and alignment:
  - All outputs are registered, one cycle after the counter state they describe.
  - de, hs, vs, field, data, x_cnt, y_cnt, sof and eol are mutually aligned.
  - de = horizontal active AND vertical active.
- Pattern selection:
  - pattern_sel is sampled only when h=0, v=0, field 0 (frame start), so a pattern change never tears a frame.
  - Outside de, data = 0.
- Colour bars:
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
  - Bar width BW = H_ACTIVE/8 (integer division); the bar index saturates at 7, so the last bar absorbs the remainder.
  - Bar index comes from a bar counter; no divider.
  - Full-scale components: RGB565 white = 16'hFFFF; RGB888 white = 24'hFFFFFF.
- Ramp: grey level = x_cnt[7:0], mapped to each component's MSBs.
- Solid: data = SOLID_COLOR.
- Checkerboard: white when x_cnt[5]^y_cnt[5], else black.
- Boundary conditions:
  - sof fires only in field 0; eol fires every active line.
  - A reset asserted mid-line takes effect on the next edge; outputs match the reset values in the following cycle.
  - Parameter sanity (H_ACTIVE+H_FP+H_SYNC < H_TOTAL, V_ACTIVE_f+V_FP_f+V_SYNC_f < V_TOTAL_f, HV_OFFSET_f < H_TOTAL) is checked by elaboration-time assertions, not at runtime.

Test Plan:
- Reset, then enable=1, INTERLACED=0, default horizontals -> first de high at cycle 1 for 768 cycles, hs high for 100 cycles starting at the 781st cycle of the line, line period 944; sof pulses once per 312-line frame.
- INTERLACED=1 -> field alternates; field 0 lasts 312*944 cycles, field 1 lasts 313*944 cycles. Field 0 vs rises at h_cnt 0 of v 294; field 1 vs rises at h_cnt 472 of v 294 and falls at h_cnt 472 of v 299.
- pattern_sel=0, DATA_W=16 -> x 0..95 = 16'hFFFF, x 96..191 = 16'hFFE0, x 672..767 = 16'h0000. Repeat with DATA_W=24 -> x 96 = 24'hFFFF00.
- pattern_sel changed 0->2 mid-frame -> bars continue until the next sof; solid 16'hF800 appears from the sof pixel onward.
- Interlaced y_cnt check: field 1, v_cnt 10 -> y_cnt 21. pattern 3 at x=32, y=0 -> white.
- reset asserted mid-active-line, and separately enable dropped mid-frame -> all outputs return to reset values within one cycle; restart begins at h=0, v=0, field 0 with de high one cycle after enable returns.
